// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: owner codes shared by the arbiter FSM state and its read tag.
package data_memory_arbiter_pkg;
  localparam int OWNER_CODE_SIZE = 2;
  localparam logic [OWNER_CODE_SIZE-1:0] OWNER_NONE = 2'd0;
  localparam logic [OWNER_CODE_SIZE-1:0] OWNER_CORE = 2'd1;
  localparam logic [OWNER_CODE_SIZE-1:0] OWNER_DMA  = 2'd2;
  typedef enum logic [OWNER_CODE_SIZE-1:0] {
    S_IDLE = OWNER_NONE,
    S_CORE = OWNER_CORE,
    S_DMA  = OWNER_DMA
  } state_t;
  typedef enum logic [OWNER_CODE_SIZE-1:0] {
    TAG_NONE = OWNER_NONE,
    TAG_CORE = OWNER_CORE,
    TAG_DMA  = OWNER_DMA
  } owner_t;
endpackage

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: core, DMA and data_memory port signals around the arbiter.
interface data_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_stall;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, mem_q,
    output core_stall, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_address, mem_data, mem_wren
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, mem_q,
    input  core_stall, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/data_memory_arbiter_reg.sv
// data_memory_arbiter_reg: enabled register with synchronous active-high clear.
module data_memory_arbiter_reg #(
  parameter type T = logic
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  T     d,
  output T     q
);
  always_ff @(posedge clock)
    if (reset) q <= T'(0);
    else if (en) q <= d;
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares data_memory between core MEM stage and DMA with burst-limited fairness.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input logic clock,
  input logic reset,
  data_memory_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef logic [DATA_WIDTH-1:0] data_t;
  state_t state, state_n;
  logic [BW-1:0] burst_cnt, burst_n;
  logic at_max, core_keep, dma_keep, gnt_core, gnt_dma;
  owner_t tag_d, tag_q;
  data_t core_rdata_q, dma_rdata_q;
  always_ff @(posedge clock)
    if (reset) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
    end
  // The current owner keeps the port unless the other side waits and the burst is spent.
  always_comb begin
    at_max    = burst_cnt == BW'(MAX_BURST);
    core_keep = bus.core_req && !(bus.dma_req && at_max);
    dma_keep  = bus.dma_req && !(bus.core_req && at_max);
    gnt_core  = !reset && (state == S_DMA ? bus.core_req && !dma_keep : core_keep);
    gnt_dma   = !reset && (state == S_DMA ? dma_keep : bus.dma_req && !core_keep);
    state_n   = gnt_core ? S_CORE : gnt_dma ? S_DMA : S_IDLE;
    burst_n   = state_n == S_IDLE ? '0 :
                state_n != state  ? BW'(1) :
                at_max            ? burst_cnt : burst_cnt + BW'(1);
    tag_d     = gnt_core && !bus.core_we ? TAG_CORE :
                gnt_dma  && !bus.dma_we  ? TAG_DMA  : TAG_NONE;
  end
  assign bus.core_stall  = !reset && bus.core_req && !gnt_core;
  assign bus.dma_gnt     = gnt_dma;
  assign bus.mem_wren    = gnt_core ? bus.core_we : gnt_dma && bus.dma_we;
  assign bus.mem_address = gnt_core ? bus.core_addr  : gnt_dma ? bus.dma_addr  : '0;
  assign bus.mem_data    = gnt_core ? bus.core_wdata : gnt_dma ? bus.dma_wdata : '0;
  // Gating by reset drops a response whose read was issued just before reset.
  assign bus.core_rvalid = !reset && tag_q == TAG_CORE;
  assign bus.dma_rvalid  = !reset && tag_q == TAG_DMA;
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_q : core_rdata_q;
  assign bus.dma_rdata   = bus.dma_rvalid  ? bus.mem_q : dma_rdata_q;
  data_memory_arbiter_reg #(.T(owner_t)) u_tag (
    .clock(clock), .reset(reset), .en(1'b1), .d(tag_d), .q(tag_q)
  );
  data_memory_arbiter_reg #(.T(data_t)) u_core_rdata (
    .clock(clock), .reset(reset), .en(bus.core_rvalid), .d(bus.mem_q), .q(core_rdata_q)
  );
  data_memory_arbiter_reg #(.T(data_t)) u_dma_rdata (
    .clock(clock), .reset(reset), .en(bus.dma_rvalid), .d(bus.mem_q), .q(dma_rdata_q)
  );
endmodule
